// File: rtl/stage_m_lsu.sv
// M-stage load/store unit: drives a req/ack data bus and fills the M/W pipeline register.
// Define LSU_BUS_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES with EXC_DBE.
module stage_m_lsu #(
  parameter logic [4:0]  EXC_ADEL       = 5'd4,
  parameter logic [4:0]  EXC_ADES       = 5'd5,
  parameter logic [4:0]  EXC_DBE        = 5'd7,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_ld,
  input  logic        in_st,
  input  logic [1:0]  in_size,
  input  logic        in_sext,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_sdata,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_exc,
  input  logic        in_we,
  input  logic [4:0]  in_waddr,
  input  logic [31:0] in_wdata,
  input  logic        stall_in,
  input  logic        flush,
  output logic        busy,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        w_valid,
  output logic [31:0] w_pc,
  output logic [4:0]  w_exc,
  output logic        w_we,
  output logic [4:0]  w_waddr,
  output logic [31:0] w_data
);

  typedef enum logic [1:0] {StIdle, StWait, StHold} stateT;

  stateT       state;
  logic        mem, misalign, issue, reqRaw, done, err, errNow, timeout, flushing;
  logic        flushSeen, heldErr, loadDone;
  logic [4:0]  exc, excFinal;
  logic [31:0] sh, rdExt, heldData, wDataNext;

  always_comb begin
    mem = in_valid & (in_ld | in_st);
    case (in_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = in_addr[0];
      default: misalign = |in_addr[1:0];
    endcase
    if (in_exc != 5'd0)         exc = in_exc;
    else if (mem && misalign)   exc = in_ld ? EXC_ADEL : EXC_ADES;
    else                        exc = 5'd0;
    issue = mem & (exc == 5'd0) & ~flush;
  end

`ifdef LSU_BUS_TIMEOUT_EN
  logic [4:0] cnt;

  // Counter sits at zero outside WAIT, so it is cleared on every WAIT entry.
  always_ff @(posedge clk) begin
    if (reset || state != StWait)         cnt <= 5'd0;
    else if (cnt != 5'(TIMEOUT_CYCLES))   cnt <= cnt + 5'd1;
  end

  assign timeout = (state == StWait) & (cnt == 5'(TIMEOUT_CYCLES)) & ~bus_ack;
`else
  assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    reqRaw   = ((state == StIdle) & issue) | ((state == StWait) & ~timeout);
    done     = ((state == StIdle) & issue & bus_ack) | ((state == StWait) & (bus_ack | timeout));
    err      = timeout;
    flushing = flush | flushSeen;
    busy     = ~reset & (((state == StIdle) & issue & ~bus_ack) |
                         ((state == StWait) & ~bus_ack & ~timeout));

    bus_req   = ~reset & reqRaw;
    bus_we    = bus_req & in_st;
    bus_addr  = bus_req ? {in_addr[31:2], 2'b00} : 32'd0;
    bus_be    = 4'd0;
    bus_wdata = 32'd0;
    if (bus_req) begin
      case (in_size)
        2'd0: begin
          bus_be    = 4'b0001 << in_addr[1:0];
          bus_wdata = {4{in_sdata[7:0]}};
        end
        2'd1: begin
          bus_be    = in_addr[1] ? 4'b1100 : 4'b0011;
          bus_wdata = {2{in_sdata[15:0]}};
        end
        default: begin
          bus_be    = 4'b1111;
          bus_wdata = in_sdata;
        end
      endcase
    end
  end

  always_comb begin
    sh = bus_rdata >> {in_addr[1:0], 3'b000};
    case (in_size)
      2'd0:    rdExt = in_sext ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
      2'd1:    rdExt = in_sext ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
      default: rdExt = sh;
    endcase

    // In HOLD the bus is idle; the latched result stands in for bus_rdata.
    errNow   = (state == StHold) ? heldErr : err;
    loadDone = mem & in_ld & (exc == 5'd0) & ((state == StHold) | done);
    if (exc != 5'd0)  excFinal = exc;
    else if (errNow)  excFinal = EXC_DBE;
    else              excFinal = 5'd0;

    if (errNow)         wDataNext = 32'd0;
    else if (loadDone)  wDataNext = (state == StHold) ? heldData : rdExt;
    else                wDataNext = in_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      flushSeen <= 1'b0;
      heldData  <= 32'd0;
      heldErr   <= 1'b0;
      w_valid   <= 1'b0;
      w_pc      <= 32'd0;
      w_exc     <= 5'd0;
      w_we      <= 1'b0;
      w_waddr   <= 5'd0;
      w_data    <= 32'd0;
    end else begin
      case (state)
        StIdle: begin
          if (issue && !bus_ack) begin
            state <= StWait;
          end else if (issue && stall_in) begin
            state    <= StHold;
            heldData <= rdExt;
            heldErr  <= 1'b0;
          end
        end
        StWait: begin
          if (done) begin
            flushSeen <= 1'b0;
            if (flushing || !stall_in) begin
              state <= StIdle;
            end else begin
              state    <= StHold;
              heldData <= rdExt;
              heldErr  <= err;
            end
          end else if (flush) begin
            flushSeen <= 1'b1;
          end
        end
        StHold: begin
          if (!stall_in) state <= StIdle;
        end
        default: state <= StIdle;
      endcase

      // A flushed in-flight access is discarded even if the pipe is stalled.
      if (((state == StWait) && done && flushing) || (!stall_in && !busy && flush)) begin
        w_valid <= 1'b0;
        w_pc    <= 32'd0;
        w_exc   <= 5'd0;
        w_we    <= 1'b0;
        w_waddr <= 5'd0;
        w_data  <= 32'd0;
      end else if (!stall_in && !busy) begin
        w_valid <= in_valid;
        w_pc    <= in_pc;
        w_exc   <= excFinal;
        w_we    <= in_we & (excFinal == 5'd0);
        w_waddr <= in_waddr;
        w_data  <= wDataNext;
      end
    end
  end

endmodule

// File: tb/tb_stage_m_lsu.sv
// Directed bench for stage_m_lsu: expected W entries are queued at drive time and
// popped when the write-back register updates; bus signals are checked in place.
module tb_stage_m_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ld, in_st, in_sext, in_we;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_sdata, in_pc, in_wdata;
  logic [4:0]  in_exc, in_waddr;
  logic        stall_in, flush, busy, bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        w_valid, w_we;
  logic [31:0] w_pc, w_data;
  logic [4:0]  w_exc, w_waddr;

  int vectors = 0;
  int miscompares = 0;
  int ackCount = 0;
  int n0;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] data;
  } wexpT;

  wexpT sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) if (bus_req && bus_ack) ackCount <= ackCount + 1;

  stage_m_lsu dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ld(in_ld), .in_st(in_st), .in_size(in_size),
    .in_sext(in_sext), .in_addr(in_addr), .in_sdata(in_sdata), .in_pc(in_pc),
    .in_exc(in_exc), .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .stall_in(stall_in), .flush(flush), .busy(busy),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .w_valid(w_valid), .w_pc(w_pc), .w_exc(w_exc), .w_we(w_we),
    .w_waddr(w_waddr), .w_data(w_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expectW(input logic v, input logic [31:0] pc, input logic [4:0] exc,
                         input logic we, input logic [4:0] waddr, input logic [31:0] data);
    wexpT e;
    e.v = v; e.pc = pc; e.exc = exc; e.we = we; e.waddr = waddr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic checkW(input string tag);
    wexpT e;
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".w_valid"}, 32'(w_valid), 32'(e.v));
      chk({tag, ".w_pc"},    w_pc,           e.pc);
      chk({tag, ".w_exc"},   32'(w_exc),   32'(e.exc));
      chk({tag, ".w_we"},    32'(w_we),    32'(e.we));
      chk({tag, ".w_waddr"}, 32'(w_waddr), 32'(e.waddr));
      chk({tag, ".w_data"},  w_data,         e.data);
    end
  endtask

  task automatic setOp(input logic ld, input logic st, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] pc,
                       input logic we, input logic [4:0] waddr, input logic [31:0] wdata);
    in_valid = 1'b1; in_ld = ld; in_st = st; in_size = size; in_sext = sext;
    in_addr = addr; in_sdata = sdata; in_pc = pc; in_we = we; in_waddr = waddr;
    in_wdata = wdata; in_exc = 5'd0;
  endtask

  task automatic idleIn();
    in_valid = 1'b0; in_ld = 1'b0; in_st = 1'b0; in_size = 2'd0; in_sext = 1'b0;
    in_addr = 32'd0; in_sdata = 32'd0; in_pc = 32'd0; in_we = 1'b0; in_waddr = 5'd0;
    in_wdata = 32'd0; in_exc = 5'd0;
  endtask

  initial begin
    reset = 1'b1; stall_in = 1'b0; flush = 1'b0; bus_ack = 1'b0; bus_rdata = 32'd0;
    idleIn();
    repeat (2) @(negedge clk);
    chk("rst.w_valid", 32'(w_valid), 32'd0);
    chk("rst.w_pc", w_pc, 32'd0);
    chk("rst.w_data", w_data, 32'd0);
    setOp(1, 0, 2'd2, 0, 32'h100, 0, 32'h1000, 1, 5'd5, 32'h111);
    #1 chk("rst.bus_req", 32'(bus_req), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    idleIn();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // lw, zero wait states
    setOp(1, 0, 2'd2, 0, 32'h100, 0, 32'h1000, 1, 5'd5, 32'h111);
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    expectW(1, 32'h1000, 5'd0, 1, 5'd5, 32'hDEADBEEF);
    #1 chk("lw.req", 32'(bus_req), 32'd1);
    chk("lw.be", 32'(bus_be), 32'hF);
    chk("lw.addr", bus_addr, 32'h100);
    chk("lw.busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkW("lw");

    // lb sign-extended, three wait cycles
    setOp(1, 0, 2'd0, 1, 32'h103, 0, 32'h1004, 1, 5'd6, 32'h222);
    bus_ack = 1'b0; bus_rdata = 32'h80FFFFFF;
    expectW(1, 32'h1004, 5'd0, 1, 5'd6, 32'hFFFFFF80);
    for (int i = 0; i < 3; i++) begin
      #1 chk("lb.busy", 32'(busy), 32'd1);
      chk("lb.be", 32'(bus_be), 32'h8);
      @(negedge clk);
    end
    bus_ack = 1'b1;
    #1 chk("lb.busy_ack", 32'(busy), 32'd0);
    @(negedge clk);
    checkW("lb");
    bus_ack = 1'b0;

    // sh with one wait cycle, completes once
    n0 = ackCount;
    setOp(0, 1, 2'd1, 0, 32'h102, 32'h1234ABCD, 32'h1008, 0, 5'd0, 32'h77);
    expectW(1, 32'h1008, 5'd0, 0, 5'd0, 32'h77);
    #1 chk("sh.we", 32'(bus_we), 32'd1);
    chk("sh.be", 32'(bus_be), 32'hC);
    chk("sh.wdata", bus_wdata, 32'hABCDABCD);
    chk("sh.busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1 chk("sh.req_wait", 32'(bus_req), 32'd1);
    chk("sh.addr_wait", bus_addr, 32'h100);
    bus_ack = 1'b1;
    #1 chk("sh.busy_ack", 32'(busy), 32'd0);
    @(negedge clk);
    checkW("sh");
    bus_ack = 1'b0; idleIn();
    #1 chk("sh.req_after", 32'(bus_req), 32'd0);
    chk("sh.acks", 32'(ackCount - n0), 32'd1);
    @(negedge clk);

    // misaligned accesses, upstream exception, non-memory op
    setOp(1, 0, 2'd2, 0, 32'h101, 0, 32'h100C, 1, 5'd7, 32'h333);
    expectW(1, 32'h100C, 5'd4, 0, 5'd7, 32'h333);
    #1 chk("adel.req", 32'(bus_req), 32'd0);
    chk("adel.busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkW("adel");
    setOp(0, 1, 2'd2, 0, 32'h102, 32'h5, 32'h1010, 0, 5'd0, 32'h444);
    expectW(1, 32'h1010, 5'd5, 0, 5'd0, 32'h444);
    #1 chk("ades.req", 32'(bus_req), 32'd0);
    @(negedge clk);
    checkW("ades");
    setOp(1, 0, 2'd2, 0, 32'h101, 0, 32'h1014, 1, 5'd7, 32'h555);
    in_exc = 5'd3;
    expectW(1, 32'h1014, 5'd3, 0, 5'd7, 32'h555);
    @(negedge clk);
    checkW("upexc");
    setOp(0, 0, 2'd2, 0, 32'h3, 0, 32'h1018, 1, 5'd9, 32'h666);
    expectW(1, 32'h1018, 5'd0, 1, 5'd9, 32'h666);
    #1 chk("nonmem.req", 32'(bus_req), 32'd0);
    @(negedge clk);
    checkW("nonmem");

    // sw completing under a 4-cycle stall
    n0 = ackCount;
    setOp(0, 1, 2'd2, 0, 32'h104, 32'hCAFEF00D, 32'h101C, 0, 5'd0, 32'h888);
    stall_in = 1'b1; bus_ack = 1'b1;
    expectW(1, 32'h101C, 5'd0, 0, 5'd0, 32'h888);
    #1 chk("sws.req", 32'(bus_req), 32'd1);
    chk("sws.wdata", bus_wdata, 32'hCAFEF00D);
    chk("sws.busy", 32'(busy), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1 chk("sws.hold_req", 32'(bus_req), 32'd0);
      chk("sws.hold_busy", 32'(busy), 32'd0);
      chk("sws.hold_wpc", w_pc, 32'h1018);
      @(negedge clk);
    end
    stall_in = 1'b0;
    #1 chk("sws.release_req", 32'(bus_req), 32'd0);
    @(negedge clk);
    checkW("sws");
    bus_ack = 1'b0; idleIn();
    #1 chk("sws.acks", 32'(ackCount - n0), 32'd1);
    chk("sws.idle_req", 32'(bus_req), 32'd0);
    @(negedge clk);

    // lhu under stall: latched data must survive a changing bus_rdata
    setOp(1, 0, 2'd1, 0, 32'h102, 0, 32'h1020, 1, 5'd10, 32'h999);
    stall_in = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h80010000;
    expectW(1, 32'h1020, 5'd0, 1, 5'd10, 32'h00008001);
    #1 chk("lhs.busy", 32'(busy), 32'd0);
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = 32'h12345678;
    #1 chk("lhs.hold_req", 32'(bus_req), 32'd0);
    @(negedge clk);
    stall_in = 1'b0;
    @(negedge clk);
    checkW("lhs");

    // flush while waiting: ack still awaited, then W cleared
    setOp(1, 0, 2'd2, 0, 32'h200, 0, 32'h1024, 1, 5'd11, 32'hAAA);
    expectW(0, 32'd0, 5'd0, 0, 5'd0, 32'd0);
    #1 chk("fl.busy", 32'(busy), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("fl.req", 32'(bus_req), 32'd1);
    chk("fl.busy_flush", 32'(busy), 32'd1);
    @(negedge clk);
    flush = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFF0000;
    #1 chk("fl.busy_ack", 32'(busy), 32'd0);
    @(negedge clk);
    checkW("fl");
    bus_ack = 1'b0; idleIn();
    #1 chk("fl.idle_req", 32'(bus_req), 32'd0);
    @(negedge clk);

`ifdef LSU_BUS_TIMEOUT_EN
    setOp(1, 0, 2'd2, 0, 32'h300, 0, 32'h1028, 1, 5'd12, 32'hBBB);
    expectW(1, 32'h1028, 5'd7, 0, 5'd12, 32'd0);
    for (int i = 0; i < 17; i++) begin
      #1 chk("to.req", 32'(bus_req), 32'd1);
      @(negedge clk);
    end
    #1 chk("to.req_drop", 32'(bus_req), 32'd0);
    chk("to.busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkW("to");
    idleIn();
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stage_m_lsu.md
Name: stage_m_lsu

Overview:
- Memory stage of the five-stage pipeline, and the consumer of the E-stage output register (effective address, store data, write-back fields, exception code).
- Turns load/store micro-ops into transactions on a req/ack data-bus master port.
- Checks alignment, generates byte enables, and extracts and extends load data.
- Registers the result into the M/W pipeline register. Raises `busy` to the pipeline controller while a transaction is outstanding.

Parameters:
- EXC_ADEL, 4, exception code for a misaligned load
- EXC_ADES, 5, exception code for a misaligned store
- EXC_DBE, 7, exception code for a bus timeout (only used with the optional feature)
- TIMEOUT_CYCLES, 16, number of WAIT cycles before a bus error is raised (only used with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  the M-stage slot holds a valid instruction
- in_ld  in  1  the instruction is a load
- in_st  in  1  the instruction is a store
- in_size  in  2  access size: 0 = byte, 1 = half, 2 = word (3 is treated as word)
- in_sext  in  1  sign-extend load data
- in_addr  in  32  effective address (ALU result)
- in_sdata  in  32  rt value to be stored
- in_pc  in  32  PC of the instruction
- in_exc  in  5  exception already raised upstream; 0 means none
- in_we, in_waddr, in_wdata  in  1/5/32  write-back fields coming from E
- stall_in  in  1  global stall; the M/W register must hold
- flush  in  1  clear the M/W register and suppress any new request
- busy  out  1  stall request to the pipeline controller
- bus_req, bus_we  out  1/1  bus request and write strobe
- bus_addr  out  32  word-aligned address ({in_addr[31:2],2'b00})
- bus_be  out  4  byte enables
- bus_wdata  out  32  store data
- bus_ack  in  1  bus completion
- bus_rdata  in  32  read data, valid in the cycle bus_ack is high
- w_valid, w_pc, w_exc, w_we, w_waddr, w_data  out  1/32/5/1/5/32  M/W pipeline register

Behaviour:
- Reset:
  - All outputs are 0 and the state is IDLE.
  - Reset during WAIT abandons the transaction; the bus is required to reset together with this block.
- Memory operation: `mem = in_valid & (in_ld | in_st)`.
- Alignment fault:
  - A fault occurs for a half access with addr[0]=1, or a word access with addr[1:0]≠0.
  - The fault code is EXC_ADEL for a load and EXC_ADES for a store.
  - Priority: in_exc (if nonzero), then the alignment fault, then none.
- Issue condition: `issue = mem & (exc==0) & ~flush`.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
- Store data: a byte is replicated ×4; a half is replicated ×2.
- Load data:
  - `sh = rdata >> (8*addr[1:0])`.
  - Take the low 8 or 16 bits of sh and zero- or sign-extend per in_sext; a word passes through.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE:
    - bus_req = issue, driven combinationally from the inputs.
    - If issue and bus_ack arrive together, the access completes in zero wait states.
    - If issue without ack, go to WAIT.
    - If the access completes while stall_in=1, latch the load data and go to HOLD.
  - WAIT:
    - bus_req stays 1 and addr/be/wdata/we stay stable until ack.
    - On ack, go to IDLE, or to HOLD if stall_in=1.
    - A flush in WAIT does not drop the request. The ack is still awaited, then the result is discarded, the W register is cleared, and the next state is IDLE.
  - HOLD:
    - bus_req = 0; a store is never re-issued.
    - Wait for stall_in=0, then update W with the latched data and return to IDLE.
- busy:
  - busy = (state==IDLE & issue & ~bus_ack) | (state==WAIT & ~bus_ack).
  - busy is 0 in HOLD.
  - Upstream holds the in_* inputs stable while busy or stall_in is high.
- W register update:
  - The register updates on a cycle with ~stall_in & ~busy.
  - flush: all w_* are cleared to 0.
  - Otherwise:
    - w_valid = in_valid; w_pc, w_waddr and w_exc come from the inputs.
    - w_we = in_we & (exc==0).
    - w_data = the load result for a completed load; otherwise in_wdata.
  - The update never happens mid-transaction.
- A non-memory instruction or a faulting access completes the same cycle with no bus activity.

Optional Feature:
- Macro: LSU_BUS_TIMEOUT_EN.
- Defined:
  - A 5-bit counter is cleared on entering WAIT and counts each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without ack, bus_req drops and the state returns to IDLE.
  - The access completes with w_exc=EXC_DBE, w_we=0 and w_data=0 (unless in_exc≠0, which takes priority).
- Undefined: WAIT waits for bus_ack indefinitely, and there is no counter logic.

Test Plan:
- lw from 0x100 with bus_rdata=0xDEADBEEF and ack in the same cycle → bus_be=1111, busy=0; next cycle w_data=0xDEADBEEF, w_we=1.
- lb with sext=1 from 0x103, rdata=0x80FFFFFF, ack after 3 cycles → busy high for 3 cycles, bus_be=1000; then w_data=0xFFFFFF80.
- sh of 0x1234ABCD to 0x102 → bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD; the store completes exactly once.
- lw from 0x101 → no bus_req, w_exc=4, w_we=0; sw to 0x102 → w_exc=5.
- sw completes while stall_in=1 for 4 cycles → state HOLD, bus_req=0 throughout (exactly one ack consumed), W updates when stall_in drops.
- LSU_BUS_TIMEOUT_EN: no ack for 16 WAIT cycles → bus_req drops, w_exc=7, w_we=0; flush during WAIT then ack → W cleared and IDLE.
